// File: rtl/trap_csr.sv
// Machine-mode trap CSR unit: holds mstatus/mie/mtvec/mscratch/mepc/mcause/mip,
// arbitrates interrupt sources into one held request and records traps from the PC unit.
module trap_csr #(
  parameter int                 PC_SIZE   = 32,
  parameter logic [PC_SIZE-1:0] MTVEC_RST = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trap_i_ext_irq,
  input  logic               trap_i_sft_irq,
  input  logic               trap_i_tmr_irq,
  output logic               trap_o_interrupt,
  input  logic               trap_i_interrupt_ack,
  input  logic               trap_i_vld_4irqexcp,
  input  logic [PC_SIZE-1:0] trap_i_wbck_epc,
  input  logic               trap_i_excp,
  input  logic [3:0]         trap_i_excp_code,
  input  logic               trap_i_mret,
  output logic               trap_o_mret_flush,
  output logic [PC_SIZE-1:0] trap_o_mret_pc,
  output logic [PC_SIZE-1:0] trap_o_mtvec,
  input  logic               csr_i_ena,
  input  logic               csr_i_wr,
  input  logic [11:0]        csr_i_addr,
  input  logic [PC_SIZE-1:0] csr_i_wdata,
  output logic [PC_SIZE-1:0] csr_o_rdata,
  output logic               csr_o_ill
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  typedef enum logic {IDLE, PEND} irq_state_t;

  irq_state_t         state, state_next;
  logic [3:0]         irq_code, irq_code_next;
  logic               mstatus_mie, mstatus_mpie;
  logic               mie_ext, mie_tmr, mie_sft;
  logic               mip_ext, mip_tmr, mip_sft;
  logic [PC_SIZE-1:0] mtvec, mscratch, mepc, mcause;
  logic [PC_SIZE-1:0] rdata;
  logic               addr_ok;
  logic               wr_en;
  logic               trap_rec;
  logic               pend_ext, pend_tmr, pend_sft;

  assign wr_en    = csr_i_ena & csr_i_wr;
  assign trap_rec = trap_i_vld_4irqexcp;
  assign pend_ext = mip_ext & mie_ext;
  assign pend_tmr = mip_tmr & mie_tmr;
  assign pend_sft = mip_sft & mie_sft;

  always_comb begin
    rdata   = '0;
    addr_ok = 1'b1;
    case (csr_i_addr)
      ADDR_MSTATUS: begin
        rdata[3] = mstatus_mie;
        rdata[7] = mstatus_mpie;
      end
      ADDR_MIE: begin
        rdata[3]  = mie_sft;
        rdata[7]  = mie_tmr;
        rdata[11] = mie_ext;
      end
      ADDR_MTVEC:    rdata = mtvec;
      ADDR_MSCRATCH: rdata = mscratch;
      ADDR_MEPC:     rdata = mepc;
      ADDR_MCAUSE:   rdata = mcause;
      ADDR_MIP: begin
        rdata[3]  = mip_sft;
        rdata[7]  = mip_tmr;
        rdata[11] = mip_ext;
      end
      default: addr_ok = 1'b0;
    endcase
  end

  assign csr_o_rdata = rdata;
  assign csr_o_ill   = csr_i_ena & ~addr_ok;

  // Once pending, the latched cause is frozen until the trap is recorded or cancelled.
  always_comb begin
    state_next    = state;
    irq_code_next = irq_code;
    case (state)
      IDLE: begin
        if (mstatus_mie & (pend_ext | pend_tmr | pend_sft)) begin
          state_next = PEND;
          if (pend_ext)      irq_code_next = 4'd11;
          else if (pend_sft) irq_code_next = 4'd3;
          else               irq_code_next = 4'd7;
        end
      end
      PEND: begin
        if ((trap_i_interrupt_ack & trap_i_vld_4irqexcp) | (trap_i_excp & ~trap_i_interrupt_ack))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      irq_code <= '0;
      mip_ext  <= 1'b0;
      mip_tmr  <= 1'b0;
      mip_sft  <= 1'b0;
    end else begin
      state    <= state_next;
      irq_code <= irq_code_next;
      mip_ext  <= trap_i_ext_irq;
      mip_tmr  <= trap_i_tmr_irq;
      mip_sft  <= trap_i_sft_irq;
    end
  end

  // Trap record beats mret, which beats a software write of mstatus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap_rec) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (trap_i_mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_en && csr_i_addr == ADDR_MSTATUS) begin
      mstatus_mie  <= csr_i_wdata[3];
      mstatus_mpie <= csr_i_wdata[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc   <= '0;
      mcause <= '0;
    end else if (trap_rec) begin
      mepc <= {trap_i_wbck_epc[PC_SIZE-1:1], 1'b0};
      if (trap_i_interrupt_ack)
        mcause <= {1'b1, {(PC_SIZE-5){1'b0}}, irq_code};
      else
        mcause <= {{(PC_SIZE-4){1'b0}}, trap_i_excp_code};
    end else if (wr_en) begin
      if (csr_i_addr == ADDR_MEPC)   mepc   <= {csr_i_wdata[PC_SIZE-1:1], 1'b0};
      if (csr_i_addr == ADDR_MCAUSE) mcause <= csr_i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_ext  <= 1'b0;
      mie_tmr  <= 1'b0;
      mie_sft  <= 1'b0;
      mtvec    <= MTVEC_RST;
      mscratch <= '0;
    end else if (wr_en) begin
      if (csr_i_addr == ADDR_MIE) begin
        mie_ext <= csr_i_wdata[11];
        mie_tmr <= csr_i_wdata[7];
        mie_sft <= csr_i_wdata[3];
      end
      if (csr_i_addr == ADDR_MTVEC)    mtvec    <= {csr_i_wdata[PC_SIZE-1:2], 2'b00};
      if (csr_i_addr == ADDR_MSCRATCH) mscratch <= csr_i_wdata;
    end
  end

  assign trap_o_interrupt  = (state == PEND);
  assign trap_o_mret_flush = trap_i_mret;
  assign trap_o_mret_pc    = mepc;
  assign trap_o_mtvec      = mtvec;

endmodule

// File: doc/trap_csr.md
# trap_csr

Machine-mode trap and interrupt CSR unit; it sits on the other end of the PC unit's trap interface. It arbitrates interrupt sources into a single held interrupt request toward PC. It consumes PC's interrupt acknowledge, trap-valid and EPC write-back to update mepc, mcause and mstatus. It supplies mtvec for trap redirection and, on mret, a flush request carrying mepc. It also serves the EXU CSR read/write port for the machine trap CSRs.

## Interface
- PC_SIZE, 32, width of PC and CSR data
- MTVEC_RST, 32'h0000_0100, reset value of mtvec
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- trap_i_ext_irq / trap_i_sft_irq / trap_i_tmr_irq  in  1 each  level interrupt sources
- trap_o_interrupt  out  1  held interrupt request to PC
- trap_i_interrupt_ack  in  1  PC interrupt acknowledge
- trap_i_vld_4irqexcp  in  1  PC trap valid (interrupt ack or exception)
- trap_i_wbck_epc  in  PC_SIZE  EPC from PC
- trap_i_excp  in  1  exception taken this cycle
- trap_i_excp_code  in  4  exception cause code
- trap_i_mret  in  1  mret executing (single-cycle pulse)
- trap_o_mret_flush  out  1  flush request, ORed into PC flush path
- trap_o_mret_pc  out  PC_SIZE  flush target (= mepc)
- trap_o_mtvec  out  PC_SIZE  trap vector base
- csr_i_ena  in  1  CSR access valid
- csr_i_wr  in  1  1 = write, 0 = read
- csr_i_addr  in  12  CSR address
- csr_i_wdata  in  PC_SIZE  write data
- csr_o_rdata  out  PC_SIZE  read data, combinational
- csr_o_ill  out  1  unimplemented address accessed

## Operation
- CSRs and reset values:
  - mstatus 0x300: only MIE[3] and MPIE[7] are implemented; resets to 0. All other bits read as 0.
  - mie 0x304: bits 3/7/11 implemented; resets to 0.
  - mtvec 0x305: resets to MTVEC_RST; bits [1:0] are forced to 0 (direct mode).
  - mscratch 0x340: resets to 0.
  - mepc 0x341: resets to 0; bit0 is forced to 0.
  - mcause 0x342: resets to 0.
  - mip 0x344: read-only; bits 11/7/3 are registered copies of ext/tmr/sft.
- csr_o_ill = csr_i_ena & address not in this list; the access then has no effect. Writes to mip are ignored and do not raise ill.
- Interrupt FSM, two states:
  - IDLE to PEND when MIE & |(mip & mie); latch the code with priority ext 11 > sft 3 > tmr 7.
  - PEND: trap_o_interrupt = 1. The latched code stays stable even if the source drops or MIE/mie is cleared.
  - PEND to IDLE on trap_i_interrupt_ack & trap_i_vld_4irqexcp (trap recorded), or on trap_i_excp without ack (request cancelled; a still-active source re-requests after mret).
- Trap record, on trap_i_vld_4irqexcp:
  - mepc <= trap_i_wbck_epc & ~1.
  - mcause <= interrupt_ack ? {1'b1, 27'b0, latched code} : {28'b0, excp_code}. Interrupt wins over a simultaneous exception.
  - MPIE <= MIE, MIE <= 0.
- mret:
  - MIE <= MPIE, MPIE <= 1.
  - trap_o_mret_flush = trap_i_mret (combinational); trap_o_mret_pc = current mepc.
- Same-cycle conflicts:
  - A trap record overrides a CSR write to mstatus, mepc or mcause in the same cycle.
  - A trap record overrides mret. mret is ignored on the mstatus bits but the flush is still output.
  - A CSR write to other CSRs proceeds.

## Timing
- CSR read is combinational. A write is visible on the next cycle.
- Source to mip: 1 register stage. mip to PEND: 1 cycle. Source-to-trap_o_interrupt latency is therefore 2 cycles.
- trap_o_interrupt deasserts the cycle after the ack.
- mepc/mcause/mstatus update on the edge ending the trap-valid cycle.
- trap_o_mtvec is registered mtvec, stable except after a CSR write.
- Reset mid-PEND returns to IDLE with all outputs 0, except trap_o_mtvec = MTVEC_RST and trap_o_mret_pc = 0.

## Test plan
- Reset, then read all CSRs -> mtvec = 0x100, all others 0; csr_o_ill = 1 for address 0x345.
- Set mie = 0x800 and mstatus = 0x8, pulse ext_irq high -> trap_o_interrupt rises 2 cycles later. With ack, valid and epc = 0x1236: mepc = 0x1236, mcause = 0x8000000B, mstatus = 0x80, interrupt deasserts.
- With sft, tmr and ext all high -> mcause code 11. With sft and tmr high -> code 3.
- Drop the source while in PEND and hold ack off 5 cycles -> request stays high; the ack records the latched code.
- Exception code 2 with valid in the same cycle as a CSR write of mepc = 0x55 -> mepc = wbck_epc, mcause = 2.
- mret with mepc = 0x2000 and mstatus = 0x80 -> flush = 1, pc = 0x2000, next-cycle mstatus = 0x88.
